// File: rtl/uart_rx.sv
// UART receiver: recovers DBIT-data-bit frames (optional parity) from i_rx using a 16x oversampling tick.
// Each bit is sampled at its midpoint; data and error flags update together with a one-clock done strobe.
module uart_rx #(
  parameter int DBIT       = 8,
  parameter int SB_TICK    = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_rx,
  input  logic       i_s_tick,
  output logic [7:0] o_dout,
  output logic       o_rx_done_tick,
  output logic       o_frame_err,
  output logic       o_parity_err
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t     r_state, w_state_nxt;
  logic [1:0] r_sync;
  logic [4:0] r_s, w_s_nxt;
  logic [2:0] r_n, w_n_nxt;
  logic [7:0] r_b, w_b_nxt;
  logic       r_perr, w_perr_nxt;
  logic       w_done;
  logic       w_rx_s;
  logic [7:0] w_data;
  logic       w_par;

  assign w_rx_s = r_sync[1];
  // Data bits sit in the top DBIT bits of the shift register after the last shift.
  assign w_data = r_b >> (8 - DBIT);
  assign w_par  = (^w_data) ^ w_rx_s ^ 1'(PARITY_ODD);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_sync         <= 2'b11;
      r_state        <= IDLE;
      r_s            <= '0;
      r_n            <= '0;
      r_b            <= '0;
      r_perr         <= 1'b0;
      o_dout         <= '0;
      o_rx_done_tick <= 1'b0;
      o_frame_err    <= 1'b0;
      o_parity_err   <= 1'b0;
    end else begin
      r_sync         <= {r_sync[0], i_rx};
      r_state        <= w_state_nxt;
      r_s            <= w_s_nxt;
      r_n            <= w_n_nxt;
      r_b            <= w_b_nxt;
      r_perr         <= w_perr_nxt;
      o_rx_done_tick <= w_done;
      if (w_done) begin
        o_dout       <= w_data;
        o_frame_err  <= ~w_rx_s;
        o_parity_err <= (PARITY_EN != 0) ? r_perr : 1'b0;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_s_nxt     = r_s;
    w_n_nxt     = r_n;
    w_b_nxt     = r_b;
    w_perr_nxt  = r_perr;
    w_done      = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_rx_s) begin
          w_state_nxt = START;
          w_s_nxt     = '0;
        end
      end
      START: begin
        if (i_s_tick) begin
          if (r_s == 5'd7) begin
            // A line back high at the start midpoint was a glitch, not a frame.
            if (!w_rx_s) begin
              w_state_nxt = DATA;
              w_s_nxt     = '0;
              w_n_nxt     = '0;
            end else begin
              w_state_nxt = IDLE;
            end
          end else begin
            w_s_nxt = r_s + 5'd1;
          end
        end
      end
      DATA: begin
        if (i_s_tick) begin
          if (r_s == 5'd15) begin
            w_s_nxt = '0;
            w_b_nxt = {w_rx_s, r_b[7:1]};
            if (r_n == 3'(DBIT - 1))
              w_state_nxt = (PARITY_EN != 0) ? PARITY : STOP;
            else
              w_n_nxt = r_n + 3'd1;
          end else begin
            w_s_nxt = r_s + 5'd1;
          end
        end
      end
      PARITY: begin
        if (i_s_tick) begin
          if (r_s == 5'd15) begin
            w_perr_nxt  = w_par;
            w_s_nxt     = '0;
            w_state_nxt = STOP;
          end else begin
            w_s_nxt = r_s + 5'd1;
          end
        end
      end
      STOP: begin
        if (i_s_tick) begin
          if (r_s == 5'(SB_TICK - 1)) begin
            w_done      = 1'b1;
            w_state_nxt = IDLE;
          end else begin
            w_s_nxt = r_s + 5'd1;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver paired with the existing transmitter.
- Recovers 8N1 frames (optional parity) from serial line `i_rx` using the shared 16x oversampling tick `i_s_tick`.
- Delivers the received byte with a one-clock done strobe and per-frame framing/parity error flags to the host interface FIFO/register logic.

Parameters:
- DBIT, 8, number of data bits per frame; legal 5..8, LSB first.
- SB_TICK, 16, oversampling ticks for the stop bit (16 = 1 stop bit, 32 = 2 stop bits).
- PARITY_EN, 0, 1 = a parity bit follows the data bits.
- PARITY_ODD, 0, 1 = odd parity, 0 = even parity; ignored when PARITY_EN = 0.

Ports:
- i_clk  input  1  system clock; all logic on rising edge.
- i_reset_n  input  1  asynchronous, active-low reset.
- i_rx  input  1  serial line; idle high; asynchronous to i_clk.
- i_s_tick  input  1  one-clock pulse at 16x baud rate.
- o_dout  output  8  received data, right-justified; bits above DBIT-1 read 0.
- o_rx_done_tick  output  1  one-clock strobe: frame complete, outputs valid.
- o_frame_err  output  1  stop bit sampled low in the last frame.
- o_parity_err  output  1  parity mismatch in the last frame; always 0 when PARITY_EN = 0.

Behaviour:
- Reset (`i_reset_n` = 0, asynchronous assert, synchronous release):
  - state = IDLE; all counters and the shift register = 0.
  - o_dout = 0, o_rx_done_tick = 0, o_frame_err = 0, o_parity_err = 0.
  - Synchronizer flops = 1 (line idle).
- Input sync: `i_rx` passes through a 2-flop synchronizer; rx_s denotes its output, 2 clocks behind `i_rx`. All decisions use rx_s.
- Counters:
  - s: 5-bit tick counter; counts only on `i_s_tick`.
  - n: 3-bit data-bit counter.
  - b: 8-bit shift register, shifts right; each new bit enters at bit 7.
- IDLE:
  - rx_s = 0 → START, s = 0. Does not require `i_s_tick`.
- START:
  - On tick with s == 7 (start-bit midpoint): rx_s = 0 → DATA, s = 0, n = 0.
  - On tick with s == 7 and rx_s = 1: false start → IDLE. No strobe; flags unchanged.
  - Other ticks: s + 1.
- DATA:
  - On tick with s == 15: sample rx_s, b = {rx_s, b[7:1]}, s = 0.
  - If n == DBIT-1 → PARITY when PARITY_EN = 1, else STOP. Otherwise n + 1.
  - Other ticks: s + 1.
- PARITY:
  - On tick with s == 15: record perr = (XOR of the DBIT data bits XOR rx_s XOR PARITY_ODD) != 0, s = 0 → STOP.
- STOP:
  - On tick with s == SB_TICK-1 (last tick of the stop period, i.e. the stop-bit midpoint):
    - o_dout = b >> (8-DBIT).
    - o_frame_err = ~rx_s.
    - o_parity_err = perr (0 when PARITY_EN = 0).
    - o_rx_done_tick = 1 for exactly this one clock.
    - → IDLE.
  - Other ticks: s + 1.
- Output timing:
  - o_dout and the error flags are registered and update only on the done clock. They hold until the next done clock.
  - o_rx_done_tick is registered; new o_dout and flags are visible in the same clock as the strobe.
- Framing error: the frame still completes, with o_frame_err = 1 and the data as sampled. If the line is still low on return to IDLE, a new START begins immediately; this is accepted behaviour.
- `i_s_tick` absent: the FSM holds state indefinitely; no timeout.
- Reset mid-frame: immediate return to the reset values above. The remainder of the interrupted frame is resynchronised on the next falling edge seen in IDLE.
- Back-to-back frames: IDLE is re-entered at the stop midpoint, so a start edge arriving half a bit later is caught. There are no dead cycles.
- Latency: o_rx_done_tick asserts 2 clocks (sync) plus one clock after the stop-bit midpoint tick.

Test Plan:
- 8N1 byte 0xA5 (line bits 0,1,0,1,0,0,1,0,1,1), tick every 4 clocks → one o_rx_done_tick, o_dout = 0xA5, o_frame_err = 0, o_parity_err = 0.
- Glitch: `i_rx` low for 3 ticks then high → no strobe, state returns to IDLE; a following 0x3C frame is received correctly.
- Stop bit driven 0 on byte 0x81 → o_dout = 0x81, o_frame_err = 1; the next good frame 0x00 clears it to 0.
- PARITY_EN = 1, PARITY_ODD = 0: byte 0x07 with parity bit 1 → o_parity_err = 0; same byte with parity bit 0 → o_parity_err = 1.
- `i_reset_n` pulsed low during data bit 4 of 0xFF → all outputs 0 immediately, no strobe; the next frame 0x5A → o_dout = 0x5A.
- Three back-to-back frames 0x01, 0x80, 0xFF, no idle gap, DBIT = 8 → exactly three strobes, in order, all error flags 0. Repeat with DBIT = 7 and 0x7F → o_dout = 0x7F, bit 7 = 0.
